cpu_mul_pipe: RTL
=================

# cpu_mul_pipe

Fixed-latency pipelined integer multiplier in the execute path. It accepts one multiply per cycle from the execute stage and retires results to the register-file write-back port exactly `STAGES` cycles later. Every cycle it exports, per stage, whether that stage will write back and to which destination register. The hazard-detection unit uses this to raise RAW/WAW stalls in decode. The pipeline never stalls: correctness relies on decode holding dependent instructions.

## Interface
Parameters:
- `DATA_W`, 32: operand and result width.
- `REG_W`, 5: register index width.
- `STAGES`, 5: pipeline depth and write-back latency. Fixed at 5 because the hazard unit checks exactly five entries.

Ports:
- `clk`, in, 1: single clock; all state on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `issue_valid`, in, 1: a multiply is issued this cycle.
- `issue_rd`, in, REG_W: destination register of the issued multiply.
- `issue_a`, in, DATA_W: multiplicand.
- `issue_b`, in, DATA_W: multiplier.
- `kill`, in, 1: squash the entry issued on the previous cycle (the one now in stage 0), e.g. on a branch redirect.
- `mul_wb_write_back`, out, STAGES: per-stage flag, set if the stage holds a live entry that will write back. Bit i is stage i.
- `mul_wb_rd_id`, out, STAGES*REG_W: per-stage destination register. Slice i is stage i.
- `wb_valid`, out, 1: a result retires this cycle.
- `wb_rd`, out, REG_W: register written by the retiring result.
- `wb_data`, out, DATA_W: low DATA_W bits of a*b.
- `inflight`, out, 3: number of live entries across stages 0..STAGES-1.

## Operation
- **Issue.** When `issue_valid`=1, stage 0 captures `issue_a`, `issue_b`, `issue_rd` and sets valid=1. When `issue_valid`=0, stage 0 loads valid=0; its data fields are don't-care but must not be exported with valid=1.
- **Advance.** The pipeline advances every cycle: stage i+1 takes the contents of stage i. There is no hold or stall input.
- **Arithmetic.** The product is built in four steps, stage 1 through stage 4. Step k adds `(a * b[8k+7:8k]) << 8k` into a DATA_W-bit accumulator, truncated to DATA_W bits. The result is the low DATA_W bits of the product, so it is identical for signed and unsigned operands.
- **Stage 4 output.** Stage 4 holds the final product. Its entry drives `wb_valid`, `wb_rd` and `wb_data` directly from registers.
- **Tracking outputs.** `mul_wb_write_back[i]` is the valid bit of stage i and `mul_wb_rd_id` slice i is the rd of stage i. Both are pure register outputs with no combinational path from the inputs.
- **Kill.** `kill`=1 clears stage 0's valid bit as the entry moves to stage 1, so it never reaches write-back. A new issue in the same cycle is unaffected and still enters stage 0. `kill` never affects stages 1 and above.
- **Duplicate destinations.** Multiple live entries may name the same rd. Each retires in issue order and is reported independently. Preventing WAW is the hazard unit's job, not this block's.
- **inflight.** Population count of the valid bits, registered and consistent with `mul_wb_write_back` in the same cycle. Range 0..5.

## Timing
- **Latency.** A multiply issued at edge N appears in stage 0 after edge N. `wb_valid`=1 with its result is visible after edge N+4, i.e. in the 5th cycle after issue. There is one result per cycle at full throughput.
- **Tracking window.** The entry is visible on `mul_wb_write_back` from bit 0 (cycle after issue) through bit 4 (the write-back cycle), i.e. for 5 consecutive cycles.
- **Reset.** `rst_n`=0 immediately clears all valid bits, so `mul_wb_write_back`=0, `wb_valid`=0 and `inflight`=0. `wb_rd`, `wb_data` and `mul_wb_rd_id` reset to 0. Data registers may be left unreset only if they are masked by valid; the outputs listed above must still read 0.
- **Reset mid-operation.** All in-flight entries are lost and none retires after reset is released. The first issue after release retires normally 5 cycles later.
- **Simultaneous events.**
  - Issue plus retire in the same cycle: `inflight` is unchanged.
  - Kill plus issue: `inflight` is unchanged. The killed entry leaves stage 0 and the new entry fills it.
  - Kill with stage 0 empty: no effect.
- **X-propagation.** Operands with `issue_valid`=0 must not propagate X into `wb_valid` or `mul_wb_write_back`.

## Test plan
- **Single issue.** Issue a=7, b=6, rd=3 at cycle 0. Expect `mul_wb_write_back` to walk 00001→10000 over cycles 1–5, with `wb_valid`=1, `wb_rd`=3 and `wb_data`=42 at cycle 5. All other cycles have `wb_valid`=0.
- **Back-to-back.** Issue five multiplies (i*3 for i=1..5, rd=i) on consecutive cycles. Expect `inflight` to ramp 1,2,3,4,5, then results 3,6,9,12,15 on consecutive cycles with the matching rd.
- **Truncation and sign.** a=0xFFFFFFFF, b=0xFFFFFFFF gives `wb_data`=0x00000001. a=0x80000000, b=2 gives 0x00000000. a=-3, b=5 gives 0xFFFFFFF1.
- **Kill.** Issue rd=9, then assert `kill` on the next cycle together with a new issue of rd=10. Expect rd=9 to disappear from bit 1 onward and never retire, while rd=10 retires normally.
- **Async reset.** With three entries in flight, pulse `rst_n` low mid-cycle. Expect all outputs to go to 0 without waiting for a clock edge, and no retirement afterwards.
- **Same rd.** Issue rd=4 twice with a gap of one cycle. Expect two `mul_wb_write_back` bits set with rd=4 simultaneously, and two retirements in issue order.

Source files
------------

// File: rtl/cpu_mul_pipe.sv
// Five-stage fixed-latency integer multiplier with per-stage write-back tracking.
// Ports: clk, rst_n, issue_* (new op), kill (squash stage 0), mul_wb_* (per-stage
// valid/rd for hazard checks), wb_* (retiring result), inflight (live count).
module cpu_mul_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int STAGES = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      issue_valid,
    input  logic [REG_W-1:0]          issue_rd,
    input  logic [DATA_W-1:0]         issue_a,
    input  logic [DATA_W-1:0]         issue_b,
    input  logic                      kill,
    output logic [STAGES-1:0]         mul_wb_write_back,
    output logic [STAGES*REG_W-1:0]   mul_wb_rd_id,
    output logic                      wb_valid,
    output logic [REG_W-1:0]          wb_rd,
    output logic [DATA_W-1:0]         wb_data,
    output logic [2:0]                inflight
);

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [REG_W-1:0]  rd_q  [STAGES];
    logic [DATA_W-1:0] a_q   [STAGES];
    logic [DATA_W-1:0] b_q   [STAGES];
    logic [DATA_W-1:0] acc_q [STAGES];
    logic [DATA_W-1:0] acc_d [STAGES];
    logic [2:0]        cnt_q;
    logic [2:0]        cnt_d;

    // Next valid vector; kill only squashes the entry leaving stage 0.
    always_comb begin
        v_d = '0;
        v_d[0] = issue_valid;
        v_d[1] = v_q[0] & ~kill;
        for (int i = 2; i < STAGES; i++) begin
            v_d[i] = v_q[i-1];
        end
        cnt_d = '0;
        for (int i = 0; i < STAGES; i++) begin
            cnt_d = cnt_d + 3'(v_d[i]);
        end
    end

    // Stage i adds the partial product of multiplier byte i-1.
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            acc_d[i] = '0;
        end
        for (int i = 1; i < STAGES; i++) begin
            acc_d[i] = acc_q[i-1]
                     + ((a_q[i-1] * DATA_W'(b_q[i-1][8*(i-1) +: 8]))
                        << (8*(i-1)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            cnt_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                rd_q[i]  <= '0;
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                acc_q[i] <= '0;
            end
        end else begin
            v_q      <= v_d;
            cnt_q    <= cnt_d;
            rd_q[0]  <= issue_rd;
            a_q[0]   <= issue_a;
            b_q[0]   <= issue_b;
            acc_q[0] <= acc_d[0];
            for (int i = 1; i < STAGES; i++) begin
                rd_q[i]  <= rd_q[i-1];
                a_q[i]   <= a_q[i-1];
                b_q[i]   <= b_q[i-1];
                acc_q[i] <= acc_d[i];
            end
        end
    end

    always_comb begin
        mul_wb_rd_id = '0;
        for (int i = 0; i < STAGES; i++) begin
            mul_wb_rd_id[i*REG_W +: REG_W] = rd_q[i];
        end
    end

    assign mul_wb_write_back = v_q;
    assign wb_valid          = v_q[STAGES-1];
    assign wb_rd             = rd_q[STAGES-1];
    assign wb_data           = acc_q[STAGES-1];
    assign inflight          = cnt_q;

endmodule
